// File: rtl/stat_accumulator_pkg.sv
// stat_acc_pkg: shared widths, default run geometry and the FSM state type
// for the stat_accumulator block and its multiply-accumulate helper.
package stat_acc_pkg;

  // Sample word layout: {x, y}, both two's-complement signed
  localparam int X_W        = 10;
  localparam int Y_W        = 10;
  localparam int SAMPLE_W   = X_W + Y_W;

  // Accumulator widths, sized so a 150-sample run of extreme values
  // cannot overflow
  localparam int SUM_W      = 18;
  localparam int PROD_W     = X_W + Y_W;
  localparam int PROD_SUM_W = 28;

  // Sample-memory address width and default run geometry
  localparam int ADDR_W                    = 8;
  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 8'd106;
  localparam int DEF_COUNT                 = 150;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sign-extend one signed sample field to running-sum width
  function automatic logic signed [SUM_W-1:0] sextToSum(input logic signed [X_W-1:0] v);
    return SUM_W'(v);
  endfunction

endpackage

// File: rtl/stat_accumulator_if.sv
// stat_accumulator_if: run control, sample-memory port and result bus of
// the stat_accumulator. The slave modport is the accumulator itself; the
// master modport is the controller/memory side that requests runs and
// supplies sample words.
interface stat_accumulator_if;
  import stat_acc_pkg::*;

  logic                         start;
  logic [SAMPLE_W-1:0]          data_in;
  logic [ADDR_W-1:0]            R_address;
  logic                         busy;
  logic                         done;
  logic signed [SUM_W-1:0]      sum_x;
  logic signed [SUM_W-1:0]      sum_y;
  logic signed [PROD_SUM_W-1:0] sum_xy;
  logic signed [PROD_SUM_W-1:0] sum_xx;

  modport slave (
    input  start,
    input  data_in,
    output R_address,
    output busy,
    output done,
    output sum_x,
    output sum_y,
    output sum_xy,
    output sum_xx
  );

  modport master (
    output start,
    output data_in,
    input  R_address,
    input  busy,
    input  done,
    input  sum_x,
    input  sum_y,
    input  sum_xy,
    input  sum_xx
  );

endinterface

// File: rtl/stat_accumulator_mac.sv
// stat_mac: signed multiply-accumulate. The full-precision product is
// sign-extended to the accumulator width and added when enabled; a
// synchronous clear zeroes the accumulator and takes priority over enable.
module stat_mac
  import stat_acc_pkg::*;
#(
  parameter int A_W   = X_W,
  parameter int B_W   = Y_W,
  parameter int ACC_W = PROD_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prodExt;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod    = P_W'(i_a) * P_W'(i_b);
  assign w_prodExt = ACC_W'(w_prod);

  // Accumulator register: async reset, sync clear, add product when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prodExt;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/stat_accumulator.sv
// stat_accumulator: on start, walks COUNT consecutive sample-memory words
// from BASE_ADDR and accumulates sum(x), sum(y), sum(x*y) and optionally
// sum(x*x). Memory read is combinational, so every RUN edge consumes the
// word addressed during the preceding cycle.
// Optional feature: define STAT_ACC_XX_EN to build the sum(x*x) channel;
// without it sum_xx is tied to zero and its multiplier is not built.
module stat_accumulator
  import stat_acc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                COUNT     = DEF_COUNT
) (
  input logic              clk,
  input logic              rst_n,
  stat_accumulator_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COUNT - 1);

  state_e                   r_state;
  logic [ADDR_W-1:0]        r_idx;
  logic                     r_busy;
  logic                     r_done;
  logic signed [SUM_W-1:0]  r_sumX;
  logic signed [SUM_W-1:0]  r_sumY;

  logic                     w_accept;
  logic                     w_accEn;
  logic                     w_lastIdx;
  logic signed [X_W-1:0]    w_x;
  logic signed [Y_W-1:0]    w_y;
  logic signed [PROD_SUM_W-1:0] w_sumXy;
  logic signed [PROD_SUM_W-1:0] w_sumXx;

  // Split the sample word into its signed fields
  assign w_x = bus.data_in[SAMPLE_W-1:Y_W];
  assign w_y = bus.data_in[Y_W-1:0];

  // A start is honoured only outside RUN; while running it is ignored
  assign w_accept  = bus.start && (r_state != RUN);
  assign w_accEn   = (r_state == RUN);
  assign w_lastIdx = (r_idx == LAST_IDX);

  // Run controller: state, sample index and registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (w_lastIdx) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Linear sums of x and y: cleared on an accepted start, summed during RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sumX <= '0;
      r_sumY <= '0;
    end else if (w_accept) begin
      r_sumX <= '0;
      r_sumY <= '0;
    end else if (w_accEn) begin
      r_sumX <= r_sumX + sextToSum(w_x);
      r_sumY <= r_sumY + sextToSum(w_y);
    end
  end

  stat_mac #(
    .A_W   (X_W),
    .B_W   (Y_W),
    .ACC_W (PROD_SUM_W)
  ) u_macXy (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_accEn),
    .i_a   (w_x),
    .i_b   (w_y),
    .o_acc (w_sumXy)
  );

`ifdef STAT_ACC_XX_EN
  stat_mac #(
    .A_W   (X_W),
    .B_W   (X_W),
    .ACC_W (PROD_SUM_W)
  ) u_macXx (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_accEn),
    .i_a   (w_x),
    .i_b   (w_x),
    .o_acc (w_sumXx)
  );
`else
  assign w_sumXx = '0;
`endif

  // Address walks BASE_ADDR+idx while running and parks at BASE_ADDR otherwise
  assign bus.R_address = (r_state == RUN) ? (BASE_ADDR + r_idx) : BASE_ADDR;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum_x     = r_sumX;
  assign bus.sum_y     = r_sumY;
  assign bus.sum_xy    = w_sumXy;
  assign bus.sum_xx    = w_sumXx;

endmodule

// File: tb/tb_stat_accumulator.sv
// tb_stat_accumulator: randomized and directed runs of stat_accumulator.
// Each accepted start pushes the reference-model result into a scoreboard;
// a monitor pops and compares whenever done rises.
module tb_stat_accumulator;

  localparam int BASE      = 106;
  localparam int COUNT     = 150;
  localparam int LAT_BOUND = COUNT + 20;

  typedef struct {
    longint sx;
    longint sy;
    longint sxy;
    longint sxx;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] mem [256];
  expT         sbQ [$];
  int          checks = 0;
  int          errors = 0;
  bit          prevDone = 1'b0;

  always #5 clk = ~clk;

  stat_accumulator_if bus ();

  // Combinational sample memory
  assign bus.data_in = mem[bus.R_address];

  stat_accumulator #(
    .BASE_ADDR (8'd106),
    .COUNT     (150)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int toSigned10(input logic [9:0] v);
    int r;
    r = int'(v);
    if (r >= 512) r = r - 1024;
    return r;
  endfunction

  // Reference: plain integer sums over the words of one run
  function automatic expT modelRun();
    expT e;
    e = '{0, 0, 0, 0};
    for (int i = 0; i < COUNT; i++) begin
      int x;
      int y;
      x = toSigned10(mem[BASE + i][19:10]);
      y = toSigned10(mem[BASE + i][9:0]);
      e.sx  += x;
      e.sy  += y;
      e.sxy += x * y;
`ifdef STAT_ACC_XX_EN
      e.sxx += x * x;
`endif
    end
    return e;
  endfunction

  task automatic fillMem(input int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0:       mem[a] = {10'd1, 10'd2};
        1:       mem[a] = {10'h200, 10'h200};
        default: mem[a] = 20'($urandom);
      endcase
    end
  endtask

  // Monitor: compare against the oldest pending expectation when done rises
  always @(posedge clk) begin
    expT e;
    #1;
    if (bus.done && !prevDone) begin
      checkOutput("pendingOnDone", longint'(sbQ.size() > 0), 1);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("sb.sum_x",  bus.sum_x,  e.sx);
        checkOutput("sb.sum_y",  bus.sum_y,  e.sy);
        checkOutput("sb.sum_xy", bus.sum_xy, e.sxy);
        checkOutput("sb.sum_xx", bus.sum_xx, e.sxx);
      end
    end
    prevDone = bus.done;
  end

  // One run: start held for holdCycles edges, optional re-pulse at a run
  // cycle, optional asynchronous reset at a run cycle
  task automatic applyStimulus(input string tag, input int holdCycles,
                               input int repulseAt, input int resetAt,
                               input bit checkClear);
    expT e;
    int  cycles;
    bit  aborted;
    e = modelRun();
    sbQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    cycles  = 0;
    aborted = 1'b0;
    if (checkClear) begin
      checkOutput({tag, ".clearSumX"},  bus.sum_x,  0);
      checkOutput({tag, ".clearSumXy"}, bus.sum_xy, 0);
      checkOutput({tag, ".busyAfterStart"}, bus.busy, 1);
    end
    while (!bus.done && !aborted && cycles < LAT_BOUND) begin
      checkOutput({tag, ".addr"}, bus.R_address, BASE + cycles);
      bus.start = ((cycles + 1) < holdCycles) || ((cycles + 1) == repulseAt);
      if (cycles == resetAt) begin
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput({tag, ".rstBusy"},  bus.busy, 0);
        checkOutput({tag, ".rstDone"},  bus.done, 0);
        checkOutput({tag, ".rstAddr"},  bus.R_address, BASE);
        checkOutput({tag, ".rstSumX"},  bus.sum_x, 0);
        checkOutput({tag, ".rstSumY"},  bus.sum_y, 0);
        checkOutput({tag, ".rstSumXy"}, bus.sum_xy, 0);
        checkOutput({tag, ".rstSumXx"}, bus.sum_xx, 0);
        sbQ.delete();
        aborted = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    bus.start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput({tag, ".noResumeBusy"}, bus.busy, 0);
      checkOutput({tag, ".noResumeDone"}, bus.done, 0);
      checkOutput({tag, ".noResumeAddr"}, bus.R_address, BASE);
    end else begin
      checkOutput({tag, ".latency"}, cycles, COUNT);
      checkOutput({tag, ".doneAddr"}, bus.R_address, BASE);
      repeat (3) @(posedge clk);
      #1;
      checkOutput({tag, ".holdDone"}, bus.done, 1);
      checkOutput({tag, ".holdSumX"}, bus.sum_x, e.sx);
      checkOutput({tag, ".holdSumXy"}, bus.sum_xy, e.sxy);
    end
  endtask

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    fillMem(0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset.busy",   bus.busy, 0);
    checkOutput("reset.done",   bus.done, 0);
    checkOutput("reset.addr",   bus.R_address, BASE);
    checkOutput("reset.sumX",   bus.sum_x, 0);
    checkOutput("reset.sumY",   bus.sum_y, 0);
    checkOutput("reset.sumXy",  bus.sum_xy, 0);
    checkOutput("reset.sumXx",  bus.sum_xx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle.busy", bus.busy, 0);
    checkOutput("idle.done", bus.done, 0);

    $display("[TB] run: constant x=1 y=2");
    fillMem(0);
    applyStimulus("ones", 1, -1, -1, 1'b0);
    checkOutput("ones.sumX",  bus.sum_x, 150);
    checkOutput("ones.sumY",  bus.sum_y, 300);
    checkOutput("ones.sumXy", bus.sum_xy, 300);
`ifdef STAT_ACC_XX_EN
    checkOutput("ones.sumXx", bus.sum_xx, 150);
`else
    checkOutput("ones.sumXx", bus.sum_xx, 0);
`endif

    $display("[TB] run: constant x=-512 y=-512");
    fillMem(1);
    applyStimulus("minNeg", 1, -1, -1, 1'b1);
    checkOutput("minNeg.sumX",  bus.sum_x, -76800);
    checkOutput("minNeg.sumY",  bus.sum_y, -76800);
    checkOutput("minNeg.sumXy", bus.sum_xy, 39321600);
`ifdef STAT_ACC_XX_EN
    checkOutput("minNeg.sumXx", bus.sum_xx, 39321600);
`else
    checkOutput("minNeg.sumXx", bus.sum_xx, 0);
`endif

    $display("[TB] run: random words");
    fillMem(2);
    applyStimulus("rand0", 1, -1, -1, 1'b1);

    $display("[TB] run: start re-pulsed at run cycle 50");
    fillMem(2);
    applyStimulus("repulse", 1, 50, -1, 1'b0);

    $display("[TB] run: reset at run cycle 80");
    fillMem(2);
    applyStimulus("midReset", 1, -1, 80, 1'b0);

    $display("[TB] run: full run after reset");
    fillMem(0);
    applyStimulus("afterReset", 1, -1, -1, 1'b0);
    checkOutput("afterReset.sumX",  bus.sum_x, 150);
    checkOutput("afterReset.sumXy", bus.sum_xy, 300);

    $display("[TB] run: start held high from DONE");
    fillMem(2);
    applyStimulus("holdStart", 10, -1, -1, 1'b1);

    $display("[TB] run: random words again");
    fillMem(2);
    applyStimulus("rand1", 1, -1, -1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stat_accumulator.md
STAT_ACCUMULATOR -- requirements
Module: stat_accumulator

Interface
- REQ-001: Parameter BASE_ADDR, default 8'd106, SHALL be the first sample-memory address read.
- REQ-002: Parameter COUNT, default 150, SHALL be the number of samples read per run; BASE_ADDR+COUNT-1 <= 255.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: start  input  1  request a new run; sampled on the rising edge of clk.
- REQ-006: data_in  input  20  sample word from memory, {x[19:10], y[9:0]}, each two's-complement signed.
- REQ-007: R_address  output  8  sample-memory read address.
- REQ-008: busy  output  1  high while in RUN.
- REQ-009: done  output  1  high while in DONE.
- REQ-010: sum_x, sum_y  output  18 each  signed running sums of x and y.
- REQ-011: sum_xy, sum_xx  output  28 each  signed running sums of x*y and x*x.

Function
- REQ-012: FSM states SHALL be IDLE, RUN and DONE.
- REQ-013: IDLE->RUN on start=1; DONE->RUN on start=1; RUN->DONE when idx==COUNT-1; all other cases hold state.
- REQ-014: On the edge that accepts start, all sums and idx SHALL clear to 0.
- REQ-015: In RUN, R_address SHALL equal BASE_ADDR+idx.
- REQ-016: In IDLE and DONE, R_address SHALL equal BASE_ADDR.
- REQ-017: Memory read is combinational, so each RUN edge SHALL accumulate the data_in present on that edge and then increment idx.
- REQ-018: Run timing: start accepted at edge 0, accumulations at edges 1..COUNT, done high after edge COUNT; done latency is COUNT+1 edges.
- REQ-019: start while in RUN SHALL be ignored, with no restart and no clearing.
- REQ-020: Sums SHALL hold their values in DONE until the next accepted start.
- REQ-021: x and y SHALL be sign-extended before accumulation.
- REQ-022: Products SHALL be 20-bit signed, sign-extended to 28 bits; widths are sized so COUNT=150 cannot overflow, and no saturation is applied.
- REQ-023: The last address of a default run SHALL be 255 with no 8-bit wrap, and idx SHALL never exceed COUNT-1.

Reset
- REQ-024: rst_n=0 SHALL immediately force IDLE, idx=0, all sums=0, busy=0, done=0 and R_address=BASE_ADDR, including mid-run.
- REQ-025: After rst_n is released, the block SHALL wait for a new start and SHALL NOT resume an interrupted run.

Configuration
- REQ-026: With macro STAT_ACC_XX_EN defined, sum_xx SHALL accumulate x*x per REQ-017.
- REQ-027: Without STAT_ACC_XX_EN, the sum_xx register and multiplier SHALL be absent and sum_xx SHALL be tied to 0.

Structure
- REQ-028: Package stat_acc_pkg SHALL hold the state enum, the constants X_W=10, Y_W=10, SUM_W=18 and PROD_SUM_W=28, and the default BASE_ADDR and COUNT.
- REQ-029: One sub-module, stat_mac (a signed multiply-accumulate with synchronous clear and enable), SHALL be instantiated once for sum_xy and once for sum_xx.

Verification
- REQ-030: All 150 words = {x=1, y=2}, start pulse -> done after 151 edges; sum_x=150, sum_y=300, sum_xy=300, sum_xx=150.
- REQ-031: x=-512, y=-512 in all words -> sum_x=sum_y=-76800, sum_xy=sum_xx=39321600; no overflow.
- REQ-032: Address trace during a run -> R_address steps 106,107,...,255, then returns to 106 in DONE with no wrap to 0.
- REQ-033: start re-pulsed at run cycle 50 -> ignored; done still at edge 151 with correct sums.
- REQ-034: rst_n low at run cycle 80 -> all outputs 0 asynchronously; a new start then gives the full-run sums of REQ-030.
- REQ-035: Build without STAT_ACC_XX_EN -> sum_xx=0 throughout, all other sums unchanged; start held high in DONE -> new run, sums cleared first.
